// File: rtl/ila_trig_capture.sv
// ila_trig_capture
//   Pre/post-trigger capture engine feeding an ILA probe wrapper (or a dump
//   path). Valid probe samples are written into a circular buffer. A
//   masked-compare or external trigger freezes a window of DEPTH samples:
//   PRE samples before the trigger, the trigger sample itself, and
//   DEPTH-PRE-1 samples after it. The window is then replayed oldest-first
//   as a valid/ready stream.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   probe, probe_vld      sample data and its qualifier
//   trig_mask, trig_val   compare mask (1 = bit participates) and value
//   trig_ext              external trigger, qualified by probe_vld
//   arm                   start request (accepted in IDLE and DONE)
//   abort                 return to IDLE from any state; wins over arm
//   busy, done            status: capture/readout running, window delivered
//   trig_seen             sticky trigger flag, cleared on accepted arm/abort
//   out_data, out_valid,  replay stream; out_last marks the DEPTH-th sample
//   out_last, out_ready
//
// Stream handshake: a beat transfers on a clock edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data, out_valid and out_last hold their values. out_valid never
// depends combinationally on out_ready.

module ila_trig_capture #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int PRE   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] probe,
  input  logic          probe_vld,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_val,
  input  logic          trig_ext,
  input  logic          arm,
  input  logic          abort,
  output logic          busy,
  output logic          trig_seen,
  output logic          done,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int AW          = $clog2(DEPTH);
  localparam int PRE_LAST_I  = PRE - 1;
  localparam int POST_LAST_I = DEPTH - PRE - 2;
  localparam int RD_LAST_I   = DEPTH - 1;
  localparam int DEPTH_I     = DEPTH;
  localparam int PRE_I       = PRE;

  localparam logic [AW:0]   PRE_LAST  = PRE_LAST_I[AW:0];
  localparam logic [AW:0]   POST_LAST = POST_LAST_I[AW:0];
  localparam logic [AW:0]   RD_LAST   = RD_LAST_I[AW:0];
  localparam logic [AW:0]   RD_TOTAL  = DEPTH_I[AW:0];
  localparam logic [AW-1:0] PRE_A     = PRE_I[AW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_READ,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] rd_addr;
  // Sample counter in PRE_FILL/POST, read-issue counter in READ.
  logic [AW:0]   cnt;

  logic          hit;
  logic          capturing;
  logic          wr_en;
  logic          rd_issue;
  logic          xfer;
  logic          load;
  logic [1:0]    occ;
  logic [1:0]    occ_after;

  // Read pipeline: RAM output stage (rq_*) and one skid entry (sk_*).
  logic [DW-1:0] ram_q;
  logic          rq_v;
  logic          rq_last;
  logic [DW-1:0] sk_data;
  logic          sk_v;
  logic          sk_last;

  assign hit       = probe_vld & (trig_ext | (((probe ^ trig_val) & trig_mask) == '0));
  assign capturing = (state == S_PRE_FILL) || (state == S_WAIT_TRIG) || (state == S_POST);
  assign wr_en     = capturing && probe_vld && !abort;

  assign xfer = out_valid & out_ready;
  assign load = !out_valid | out_ready;

  // Entries held or in flight; a read is issued only when the output and
  // skid registers can still absorb it after this edge's transfer. This
  // keeps one beat per cycle with out_ready high and never overflows.
  assign occ       = {1'b0, out_valid} + {1'b0, sk_v} + {1'b0, rq_v};
  assign occ_after = occ - {1'b0, xfer};
  assign rd_issue  = (state == S_READ) && !abort && (cnt < RD_TOTAL) && (occ_after < 2'd2);

  assign busy = capturing || (state == S_READ);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (arm) state_nx = S_PRE_FILL;
        S_PRE_FILL:  if (probe_vld && cnt == PRE_LAST) state_nx = S_WAIT_TRIG;
        S_WAIT_TRIG: if (hit) state_nx = S_POST;
        S_POST:      if (probe_vld && cnt == POST_LAST) state_nx = S_READ;
        S_READ:      if (xfer && out_last) state_nx = S_DONE;
        S_DONE:      if (arm) state_nx = S_PRE_FILL;
        default:     state_nx = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------ pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      trig_addr <= '0;
      rd_addr   <= '0;
      cnt       <= '0;
      trig_seen <= 1'b0;
    end else if (abort) begin
      trig_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            trig_seen <= 1'b0;
          end
        end
        S_PRE_FILL: begin
          if (probe_vld) begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
          end
        end
        S_WAIT_TRIG: begin
          if (probe_vld) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (hit) begin
              trig_addr <= wr_ptr;
              trig_seen <= 1'b1;
              cnt       <= '0;
            end
          end
        end
        S_POST: begin
          if (probe_vld) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt == POST_LAST) begin
              cnt     <= '0;
              // Oldest kept sample; wraps modulo DEPTH.
              rd_addr <= trig_addr - PRE_A;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_READ: begin
          if (rd_issue) begin
            rd_addr <= rd_addr + 1'b1;
            cnt     <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= probe;
    if (rd_issue) ram_q <= mem[rd_addr];
  end

  // ------------------------------------------------- replay output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_v      <= 1'b0;
      rq_last   <= 1'b0;
      sk_v      <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      rq_v      <= 1'b0;
      sk_v      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      rq_v    <= rd_issue;
      rq_last <= rd_issue && (cnt == RD_LAST);
      if (load) begin
        if (sk_v) begin
          // Skid holds the older entry; it goes out first.
          out_valid <= 1'b1;
          out_data  <= sk_data;
          out_last  <= sk_last;
          if (rq_v) begin
            sk_data <= ram_q;
            sk_last <= rq_last;
          end else begin
            sk_v <= 1'b0;
          end
        end else if (rq_v) begin
          out_valid <= 1'b1;
          out_data  <= ram_q;
          out_last  <= rq_last;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (rq_v) begin
        sk_v    <= 1'b1;
        sk_data <= ram_q;
        sk_last <= rq_last;
      end
    end
  end

endmodule

// File: tb/tb_ila_trig_capture.sv
module tb_ila_trig_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  // ------------------------------------------------ clock / reset / DUT
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe;
  logic          probe_vld;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_val;
  logic          trig_ext;
  logic          arm;
  logic          abort;
  logic          busy;
  logic          trig_seen;
  logic          done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  always #5 clk = ~clk;

  ila_trig_capture #(.DW(DW), .DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk       (clk),
    .rst       (rst),
    .probe     (probe),
    .probe_vld (probe_vld),
    .trig_mask (trig_mask),
    .trig_val  (trig_val),
    .trig_ext  (trig_ext),
    .arm       (arm),
    .abort     (abort),
    .busy      (busy),
    .trig_seen (trig_seen),
    .done      (done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  // ------------------------------------------------------------ scoreboard
  logic [DW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change #1 after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_trig_seen"}, trig_seen, 1'b0);
    chk({tag, "_done"},      done,      1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"},  out_last,  1'b0);
    chk({tag, "_out_data"},  out_data,  8'h00);
  endtask

  // ------------------------------------------------------- vector table
  // Probe is a counter that advances on every valid cycle, starting at 0
  // in the first cycle after arm. exp_first is the first replayed value;
  // the trigger lands on counter value exp_first+PRE.
  typedef struct {
    bit            toggle;     // probe_vld 1-0-1-0 instead of constant 1
    bit            rand_ready; // out_ready random at 50% instead of high
    logic [DW-1:0] mask;
    logic [DW-1:0] val;
    int            ext_at;     // counter value for the trig_ext pulse, -1 none
    int            exp_first;
  } vec_t;

  vec_t vecs[6];

  // ------------------------------------------------------ driver tasks
  task automatic drive_idle();
    probe     = '0;
    probe_vld = 1'b0;
    trig_ext  = 1'b0;
    arm       = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_arm();
    arm       = 1'b1;
    probe_vld = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic run_capture(input vec_t v, input string tag);
    int  pc;
    int  trig_pc;
    int  p_slot;
    int  first_slot;
    int  last_xfer;
    bit  phase;
    bit  trig_chk;
    bit  held;
    bit  fin;
    bit  vld;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW-1:0] e;

    trig_mask = v.mask;
    trig_val  = v.val;
    do_arm();
    chk({tag, "_busy_after_arm"}, busy, 1'b1);
    chk({tag, "_trig_seen_after_arm"}, trig_seen, 1'b0);
    chk({tag, "_done_after_arm"}, done, 1'b0);

    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'(v.exp_first + i));

    trig_pc    = v.exp_first + PRE;
    pc         = 0;
    phase      = 1'b1;
    p_slot     = -1;
    first_slot = -1;
    last_xfer  = -1;
    trig_chk   = 1'b0;
    held       = 1'b0;
    held_d     = '0;
    held_l     = 1'b0;
    fin        = 1'b0;

    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      // Outputs of the current cycle.
      if (trig_chk) chk({tag, "_trig_seen_after_hit"}, trig_seen, 1'b1);
      trig_chk = 1'b0;
      if (held) begin
        chk({tag, "_stall_valid"}, out_valid, 1'b1);
        chk({tag, "_stall_data"}, out_data, held_d);
        chk({tag, "_stall_last"}, out_last, held_l);
      end
      if (out_valid && first_slot < 0) begin
        first_slot = cyc;
        chk({tag, "_first_valid_latency"}, first_slot, p_slot + 3);
      end
      if (done) begin
        chk({tag, "_done_after_last"}, cyc, last_xfer + 1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_all_delivered"}, exp_q.size(), 0);
        chk({tag, "_trig_seen_at_done"}, trig_seen, 1'b1);
        fin = 1'b1;
      end

      // Inputs for the next edge.
      vld       = v.toggle ? phase : 1'b1;
      phase     = ~phase;
      probe_vld = vld;
      probe     = DW'(pc);
      trig_ext  = vld && (pc == v.ext_at);
      out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!fin && vld && pc == trig_pc) begin
        chk({tag, "_trig_seen_before_hit"}, trig_seen, 1'b0);
        trig_chk = 1'b1;
      end
      if (vld && pc == v.exp_first + DEPTH - 1) p_slot = cyc;
      if (vld) pc++;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, out_data, 8'hxx);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, out_data, e);
          chk({tag, "_last"}, out_last, exp_q.size() == 0);
        end
        last_xfer = cyc;
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      tick();
    end
    trig_ext = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 0, 1);
  endtask

  // ------------------------------------------------------------- test
  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'hFF, 8'd20, -1, 16}; // basic compare trigger
    vecs[1] = '{1'b1, 1'b0, 8'hFF, 8'd20, -1, 16}; // probe_vld toggling
    vecs[2] = '{1'b0, 1'b0, 8'h0F, 8'd2,  -1, 14}; // hit inside PRE_FILL ignored
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'd20, -1, 16}; // random backpressure
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'hAA,  9,  5}; // external trigger
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h5A, -1,  0}; // zero mask: first usable sample

    drive_idle();
    trig_mask = 8'hFF;
    trig_val  = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");
    tick();
    chk_reset_outputs("idle");

    for (int i = 0; i < 6; i++) run_capture(vecs[i], $sformatf("vec%0d", i));

    // abort together with arm in the middle of POST
    begin
      int pc;
      trig_mask = 8'hFF;
      trig_val  = 8'd20;
      do_arm();
      pc = 0;
      out_ready = 1'b1;
      probe_vld = 1'b1;
      while (pc < 24) begin
        probe = DW'(pc);
        pc++;
        tick();
      end
      chk("abort_pre_busy", busy, 1'b1);
      chk("abort_pre_trig_seen", trig_seen, 1'b1);
      abort = 1'b1;
      arm   = 1'b1;
      tick();
      abort = 1'b0;
      arm   = 1'b0;
      probe_vld = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_trig_seen", trig_seen, 1'b0);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_done", done, 1'b0);
      tick();
      chk("abort_stays_idle", busy, 1'b0);
    end
    run_capture(vecs[0], "after_abort");

    // reset in the middle of READ
    begin
      int pc;
      int seen;
      trig_mask = 8'hFF;
      trig_val  = 8'd20;
      do_arm();
      pc   = 0;
      seen = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && seen < 3; cyc++) begin
        if (out_valid) seen++;
        probe_vld = 1'b1;
        probe     = DW'(pc);
        pc++;
        if (seen < 3) tick();
      end
      chk("rst_read_reached", seen, 3);
      rst = 1'b1;
      tick();
      chk_reset_outputs("rst_in_read");
      rst = 1'b0;
      drive_idle();
      tick();
      chk("rst_in_read_idle", busy, 1'b0);
    end
    run_capture(vecs[2], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
